// File: rtl/req_arbiter_4.sv
// Four-requester arbiter: grant, hold, forced release after MAX_HOLD cycles under contention.
// Define REQ_ARBITER_RR_EN for round-robin selection; the default is fixed priority (req[3] highest).
module req_arbiter_4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [1:0]       last_owner, last_owner_nxt;
  logic [3:0]       grant_nxt;
  logic [1:0]       gnt_id_nxt;
  logic             gnt_valid_nxt;
  logic             preempt_nxt;
  logic [1:0]       win_id;
  logic             owner_req;
  logic             others_req;

  assign owner_req  = req[gnt_id];
  assign others_req = |(req & ~(4'b0001 << gnt_id));

`ifdef REQ_ARBITER_RR_EN
  logic [1:0] rr_cand;
  logic       rr_found;

  // Search starts just below the previous owner and wraps, so the previous owner comes last.
  always_comb begin
    win_id   = '0;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int i = 1; i <= 4; i++) begin
      rr_cand = last_owner - 2'(i);
      if (!rr_found && req[rr_cand]) begin
        win_id   = rr_cand;
        rr_found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win_id = '0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) win_id = 2'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      gnt_id     <= '0;
      gnt_valid  <= 1'b0;
      preempt    <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      gnt_id     <= gnt_id_nxt;
      gnt_valid  <= gnt_valid_nxt;
      preempt    <= preempt_nxt;
      hold_cnt   <= hold_cnt_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    gnt_id_nxt     = gnt_id;
    gnt_valid_nxt  = gnt_valid;
    preempt_nxt    = 1'b0;
    hold_cnt_nxt   = hold_cnt;
    last_owner_nxt = last_owner;

    case (state)
      GRANT: begin
        // An owner dropping its request wins over a simultaneous timeout, so no preempt then.
        if (!owner_req) begin
          state_nxt     = RELEASE;
          grant_nxt     = '0;
          gnt_valid_nxt = 1'b0;
        end else if (hold_cnt == HOLD_LAST && others_req) begin
          state_nxt     = RELEASE;
          grant_nxt     = '0;
          gnt_valid_nxt = 1'b0;
          preempt_nxt   = 1'b1;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        grant_nxt     = '0;
        gnt_valid_nxt = 1'b0;
        if (|req) begin
          state_nxt      = GRANT;
          grant_nxt      = 4'b0001 << win_id;
          gnt_id_nxt     = win_id;
          gnt_valid_nxt  = 1'b1;
          hold_cnt_nxt   = '0;
          last_owner_nxt = win_id;
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_req_arbiter_4.sv
// Self-checking bench for req_arbiter_4 (MAX_HOLD=4): tenure-based reference model plus directed literal checks.
// Honours REQ_ARBITER_RR_EN the same way the design does.
module tb_req_arbiter_4;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  int m_owner   = -1;
  int m_tenure  = 0;
  int m_last    = 0;
  bit m_preempt = 1'b0;
  bit m_valid   = 1'b0;

  req_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant     (grant),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg, input logic ev,
                             input logic [1:0] eid, input logic ep);
    check_val({name, " grant"}, int'(grant), int'(eg));
    check_val({name, " gnt_valid"}, int'(gnt_valid), int'(ev));
    check_val({name, " preempt"}, int'(preempt), int'(ep));
    if (ev) check_val({name, " gnt_id"}, int'(gnt_id), int'(eid));
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic rs);
    @(negedge clk);
    req = r;
    rst = rs;
    @(posedge clk);
    #2;
  endtask

  function automatic int pick_winner(input logic [3:0] r, input int last);
`ifdef REQ_ARBITER_RR_EN
    for (int s = 1; s <= 4; s++) begin
      int c;
      c = (last - s + 8) % 4;
      if (r[c]) return c;
    end
`else
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  // Reference model: an owner keeps the resource until it drops, or until it has held
  // MAX_HOLD cycles while someone else waits; every release costs one idle gap cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_owner   = -1;
      m_tenure  = 0;
      m_last    = 0;
      m_preempt = 1'b0;
      m_valid   = 1'b1;
    end else if (m_valid) begin
      m_preempt = 1'b0;
      if (m_owner >= 0) begin
        bit others;
        others = 1'b0;
        for (int i = 0; i < 4; i++) if (i != m_owner && req[i]) others = 1'b1;
        if (!req[m_owner]) begin
          m_owner = -1;
        end else if (m_tenure >= MAX_HOLD && others) begin
          m_owner   = -1;
          m_preempt = 1'b1;
        end else begin
          m_tenure++;
        end
      end else if (req != 4'b0000) begin
        m_owner  = pick_winner(req, m_last);
        m_tenure = 1;
        m_last   = m_owner;
      end
    end
    #1;
    if (m_valid) begin
      checkOutput("model", (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000,
                  m_owner >= 0, 2'(m_owner), m_preempt);
      check_val("onehot grant", int'($countones(grant) <= 1), 1);
      check_val("valid matches grant", int'(gnt_valid), int'(|grant));
    end
  end

  initial begin
    bit saw_preempt;

    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    check_val("reset gnt_id", int'(gnt_id), 0);

    applyStimulus(4'b0101, 1'b0);
    checkOutput("first grant", 4'b0100, 1'b1, 2'd2, 1'b0);
    repeat (2) applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("handover gap", 4'b0000, 1'b0, 2'd0, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("handover new", 4'b0001, 1'b1, 2'd0, 1'b0);
    repeat (2) applyStimulus(4'b0000, 1'b0);

    applyStimulus(4'b1001, 1'b0);
    checkOutput("contend first", 4'b1000, 1'b1, 2'd3, 1'b0);
    repeat (3) applyStimulus(4'b1001, 1'b0);
    checkOutput("contend full tenure", 4'b1000, 1'b1, 2'd3, 1'b0);
    applyStimulus(4'b1001, 1'b0);
    checkOutput("timeout gap", 4'b0000, 1'b0, 2'd0, 1'b1);
    applyStimulus(4'b1001, 1'b0);
`ifdef REQ_ARBITER_RR_EN
    checkOutput("after timeout", 4'b0001, 1'b1, 2'd0, 1'b0);
`else
    checkOutput("after timeout", 4'b1000, 1'b1, 2'd3, 1'b0);
`endif
    repeat (4) applyStimulus(4'b1001, 1'b0);
    checkOutput("second timeout gap", 4'b0000, 1'b0, 2'd0, 1'b1);
    applyStimulus(4'b1001, 1'b0);
    checkOutput("third tenure", 4'b1000, 1'b1, 2'd3, 1'b0);
    repeat (2) applyStimulus(4'b0000, 1'b0);

    saw_preempt = 1'b0;
    for (int n = 0; n < 40; n++) begin
      applyStimulus(4'b0010, 1'b0);
      if (preempt) saw_preempt = 1'b1;
    end
    checkOutput("solo hold", 4'b0010, 1'b1, 2'd1, 1'b0);
    check_val("solo never preempted", int'(saw_preempt), 0);

    applyStimulus(4'b0001, 1'b0);
    checkOutput("drop beats timeout", 4'b0000, 1'b0, 2'd0, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("after drop", 4'b0001, 1'b1, 2'd0, 1'b0);

    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("pre reset", 4'b0100, 1'b1, 2'd2, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("mid reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    check_val("mid reset gnt_id", int'(gnt_id), 0);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("after reset", 4'b0100, 1'b1, 2'd2, 1'b0);
    repeat (2) applyStimulus(4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
